// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with return stack.
//
// One operation per rising clk edge, fixed priority:
//   ret > call > load > branch > enable > hold.
// Lower-priority controls asserted alongside a higher one have no effect.
//
// Parameters:
//   WIDTH        program-counter width (4..32)
//   DEPTH        return-stack entries (2..64)
//   OFS_W        relative-branch offset width (<= WIDTH)
//   RESET_VECTOR pc value after reset
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-high reset
//   enable       pc <= pc + 1
//   load         pc <= pre_load
//   pre_load     jump / call target
//   branch       pc <= pc + sign_extend(offset)
//   offset       two's-complement branch offset
//   call         push pc + 1, pc <= pre_load
//   ret          pop return address into pc
//   clr_err      clear sticky overflow / underflow
//   pc           current program counter (registered)
//   sp           number of valid stack entries (registered)
//   stack_full   sp == DEPTH
//   stack_empty  sp == 0
//   overflow     sticky: call attempted while full
//   underflow    sticky: ret attempted while empty

module pc_sequencer #(
    parameter int unsigned     WIDTH        = 12,
    parameter int unsigned     DEPTH        = 8,
    parameter int unsigned     OFS_W        = 8,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       load,
    input  logic [WIDTH-1:0]           pre_load,
    input  logic                       branch,
    input  logic [OFS_W-1:0]           offset,
    input  logic                       call,
    input  logic                       ret,
    input  logic                       clr_err,
    output logic [WIDTH-1:0]           pc,
    output logic [$clog2(DEPTH+1)-1:0] sp,
    output logic                       stack_full,
    output logic                       stack_empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int unsigned SP_W = $clog2(DEPTH + 1);
    localparam int unsigned AW   = $clog2(DEPTH);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [SP_W-1:0]  sp_q, sp_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    // Stack storage has no reset: entries at or above sp are never read.
    logic [WIDTH-1:0] stack_mem [DEPTH];

    logic              push;
    logic [AW-1:0]     push_idx;
    logic [AW-1:0]     pop_idx;
    logic [WIDTH-1:0]  pc_inc;
    logic signed [OFS_W-1:0] ofs_s;
    logic [WIDTH-1:0]  ofs_ext;

    assign pc_inc   = pc_q + WIDTH'(1);
    assign push_idx = AW'(sp_q);
    assign pop_idx  = AW'(sp_q - SP_W'(1));
    assign ofs_s    = offset;
    // Size cast of a signed value sign-extends; also safe when OFS_W == WIDTH.
    assign ofs_ext  = WIDTH'(ofs_s);

    assign stack_full  = (sp_q == SP_W'(DEPTH));
    assign stack_empty = (sp_q == '0);

    always_comb begin
        pc_d  = pc_q;
        sp_d  = sp_q;
        push  = 1'b0;
        // Clear happens first so a same-cycle error still leaves the flag set.
        ovf_d = ovf_q & ~clr_err;
        unf_d = unf_q & ~clr_err;

        if (ret) begin
            if (!stack_empty) begin
                pc_d = stack_mem[pop_idx];
                sp_d = sp_q - SP_W'(1);
            end else begin
                unf_d = 1'b1;
            end
        end else if (call) begin
            if (!stack_full) begin
                push = 1'b1;
                sp_d = sp_q + SP_W'(1);
                pc_d = pre_load;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (load) begin
            pc_d = pre_load;
        end else if (branch) begin
            pc_d = pc_q + ofs_ext;
        end else if (enable) begin
            pc_d = pc_inc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= RESET_VECTOR;
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            stack_mem[push_idx] <= pc_inc;
        end
    end

    assign pc        = pc_q;
    assign sp        = sp_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 12: program-counter width in bits (4 to 32).
REQ-002 SHALL have parameter DEPTH, default 8: return-stack entries (2 to 64).
REQ-003 SHALL have parameter OFS_W, default 8: relative-branch offset width in bits, less than or equal to WIDTH.
REQ-004 SHALL have parameter RESET_VECTOR, default 0: pc value after reset, WIDTH bits.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  increment pc by 1.
REQ-008 load  input  1  absolute jump: pc <= pre_load.
REQ-009 pre_load  input  WIDTH  jump/call target.
REQ-010 branch  input  1  relative jump by offset.
REQ-011 offset  input  OFS_W  two's-complement relative offset.
REQ-012 call  input  1  push return address, jump to pre_load.
REQ-013 ret  input  1  pop return address into pc.
REQ-014 clr_err  input  1  synchronous clear of sticky error flags.
REQ-015 pc  output  WIDTH  current program counter, registered.
REQ-016 sp  output  clog2(DEPTH+1)  number of valid stack entries, registered.
REQ-017 stack_full  output  1  high when sp == DEPTH, combinational from sp.
REQ-018 stack_empty  output  1  high when sp == 0, combinational from sp.
REQ-019 overflow  output  1  sticky: call attempted while full.
REQ-020 underflow  output  1  sticky: ret attempted while empty.

Function
REQ-021 SHALL evaluate exactly one operation per rising edge, selected by fixed priority: ret > call > load > branch > enable > hold.
REQ-022 ret with sp > 0 SHALL set pc <= stack[sp-1] and sp <= sp-1.
REQ-023 ret with sp == 0 SHALL leave pc and sp unchanged and set underflow.
REQ-024 call with sp < DEPTH SHALL write pc+1 (mod 2^WIDTH) to stack[sp], set sp <= sp+1 and pc <= pre_load.
REQ-025 call with sp == DEPTH SHALL leave pc, sp and stack unchanged and set overflow.
REQ-026 load SHALL set pc <= pre_load, with stack unchanged.
REQ-027 branch SHALL set pc <= pc + sign_extend(offset), computed modulo 2^WIDTH.
REQ-028 enable SHALL set pc <= pc + 1 modulo 2^WIDTH; all ones wraps to 0.
REQ-029 With no control asserted, all state SHALL hold.
REQ-030 Lower-priority inputs asserted in the same cycle SHALL be ignored entirely, with no partial effect (for example, enable does not add 1 after a load).
REQ-031 All pc updates SHALL take effect in the cycle after the edge: latency 1.
REQ-032 clr_err SHALL clear overflow and underflow at the edge.
REQ-033 If clr_err and a new error condition occur in the same cycle, the error flag SHALL end up set.
REQ-034 Stack contents at indices greater than or equal to sp SHALL be don't-care and SHALL NOT be observable.

Reset
REQ-035 While reset is high, outputs SHALL immediately (asynchronously) take pc = RESET_VECTOR, sp = 0, overflow = 0, underflow = 0, stack_empty = 1 and stack_full = 0.
REQ-036 Reset asserted mid-operation, including during a call or ret edge, SHALL override that operation.
REQ-037 Stack RAM SHALL need no reset.
REQ-038 The first operation after reset deassertion SHALL occur on the first rising edge with reset low.

Verification
REQ-039 Parameters WIDTH=12, DEPTH=8: reset, then enable for 5 cycles -> pc = 5, sp = 0, stack_empty = 1.
REQ-040 pc = 0xFFF, enable -> pc = 0x000; pc = 0x010, branch with offset = 0xF0 (-16) -> pc = 0x000; pc = 0x005, branch with offset = 0x7F -> pc = 0x084.
REQ-041 pc = 0x020, call with pre_load = 0x300 -> pc = 0x300, sp = 1; then ret -> pc = 0x021, sp = 0.
REQ-042 Perform 8 nested calls -> stack_full = 1; a 9th call -> pc unchanged, sp = 8, overflow = 1; 8 rets -> return addresses in LIFO order; a 9th ret -> underflow = 1, pc unchanged.
REQ-043 Assert ret, call, load and enable together with sp = 2 -> only the pop occurs and sp = 1; then assert load and enable together with pre_load = 0x100 -> pc = 0x100.
REQ-044 Assert reset asynchronously between edges during a call sequence -> pc = RESET_VECTOR and sp = 0 before the next edge, with the error flags cleared.
